// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: pixel raster plus per-pixel selection of the HDMI
// period (control, video preamble/guard/video, island preamble/guard/island)
// for the three downstream TMDS channel encoders.
//
// Every output is registered and describes the pixel (cx, cy) it is presented
// with. At each clock edge the logic works out the next pixel's coordinates and
// period from the current registers and the inputs present during this cycle.
// As a result, the packet slot shown on a DATA pixel is the one the source
// presented during the cycle just before that pixel. pkt_ready marks the pixels
// whose slot was taken at the edge that began them. The island start decision
// for cx = ISLAND_START follows the same rule, so it uses pkt_valid from the
// cycle before.
module hdmi_period_scheduler #(
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_SIZE  = 96,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_SIZE  = 2,
    parameter int SYNC_INVERT  = 1,
    parameter int ISLAND_START = 644
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        pkt_valid,
    input  logic        pkt_header,
    input  logic [3:0]  pkt_ch1,
    input  logic [3:0]  pkt_ch2,
    output logic        pkt_ready,
    output logic        underflow,
    output logic [11:0] cx,
    output logic [10:0] cy,
    output logic [2:0]  mode,
    output logic [1:0]  ctrl0,
    output logic [1:0]  ctrl1,
    output logic [1:0]  ctrl2,
    output logic [3:0]  island0,
    output logic [3:0]  island1,
    output logic [3:0]  island2
);

    localparam logic [11:0] HA       = 12'(H_ACTIVE);
    localparam logic [11:0] HT_LAST  = 12'(H_TOTAL - 1);
    localparam logic [11:0] HT_GUARD = 12'(H_TOTAL - 2);
    localparam logic [11:0] HT_PRE   = 12'(H_TOTAL - 10);
    localparam logic [11:0] HS_BEGIN = 12'(H_SYNC_START);
    localparam logic [11:0] HS_END   = 12'(H_SYNC_START + H_SYNC_SIZE);
    localparam logic [11:0] ISL      = 12'(ISLAND_START);
    localparam logic [10:0] VA       = 11'(V_ACTIVE);
    localparam logic [10:0] VA_LAST  = 11'(V_ACTIVE - 1);
    localparam logic [10:0] VT_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] VS_BEGIN = 11'(V_SYNC_START);
    localparam logic [10:0] VS_END   = 11'(V_SYNC_START + V_SYNC_SIZE);
    localparam logic        SYNC_INV = 1'(SYNC_INVERT);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        LGUARD,
        DATA,
        TGUARD
    } island_state_t;

    island_state_t state, state_next;
    logic [4:0]    cnt, cnt_next;
    logic [11:0]   cx_next;
    logic [10:0]   cy_next;
    logic          hsync_w, vsync_w, next_line_active;
    logic [2:0]    mode_d;
    logic [1:0]    ctrl1_d, ctrl2_d;
    logic [3:0]    island0_d, island1_d, island2_d;
    logic          ready_d, underflow_d;

    // Raster advance: coordinates of the pixel that follows the current one.
    always_comb begin
        cx_next = cx + 12'd1;
        cy_next = cy;
        if (cx == HT_LAST) begin
            cx_next = 12'd0;
            cy_next = (cy == VT_LAST) ? 11'd0 : cy + 11'd1;
        end
    end

    // Wire-level sync levels and next-line-active flag for the next pixel.
    always_comb begin
        hsync_w = ((cx_next >= HS_BEGIN) && (cx_next < HS_END)) ^ SYNC_INV;
        vsync_w = ((cy_next >= VS_BEGIN) && (cy_next < VS_END)) ^ SYNC_INV;
        next_line_active = (cy_next < VA_LAST) || (cy_next == VT_LAST);
    end

    // Island sequencer next state; cnt is the position inside the current phase.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 5'd1;
        case (state)
            IDLE: begin
                cnt_next = 5'd0;
                if ((cx_next == ISL) && pkt_valid) state_next = PRE;
            end
            PRE: if (cnt == 5'd7) begin
                state_next = LGUARD;
                cnt_next   = 5'd0;
            end
            LGUARD: if (cnt == 5'd1) begin
                state_next = DATA;
                cnt_next   = 5'd0;
            end
            DATA: if (cnt == 5'd31) begin
                state_next = TGUARD;
                cnt_next   = 5'd0;
            end
            TGUARD: if (cnt == 5'd1) begin
                state_next = IDLE;
                cnt_next   = 5'd0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 5'd0;
            end
        endcase
    end

    // Period decode for the next pixel: video beats video guard beats video preamble beats island.
    always_comb begin
        mode_d      = 3'd0;
        ctrl1_d     = 2'b00;
        ctrl2_d     = 2'b00;
        island0_d   = 4'd0;
        island1_d   = 4'd0;
        island2_d   = 4'd0;
        ready_d     = 1'b0;
        underflow_d = underflow;
        if ((cx_next < HA) && (cy_next < VA)) begin
            mode_d = 3'd1;
        end else if (next_line_active && (cx_next >= HT_GUARD)) begin
            mode_d = 3'd2;
        end else if (next_line_active && (cx_next >= HT_PRE)) begin
            ctrl1_d = 2'b01;
        end else begin
            case (state_next)
                PRE: begin
                    ctrl1_d = 2'b01;
                    ctrl2_d = 2'b01;
                end
                LGUARD, TGUARD: mode_d = 3'd4;
                DATA: begin
                    mode_d      = 3'd3;
                    ready_d     = 1'b1;
                    island0_d   = {cnt_next != 5'd0, pkt_valid & pkt_header, vsync_w, hsync_w};
                    island1_d   = pkt_valid ? pkt_ch1 : 4'd0;
                    island2_d   = pkt_valid ? pkt_ch2 : 4'd0;
                    underflow_d = underflow | ~pkt_valid;
                end
                default: ;
            endcase
        end
    end

    // Island sequencer state register; reset abandons any packet in flight.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Output registers, all describing the same pixel (cx, cy).
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cx        <= 12'd0;
            cy        <= 11'd0;
            mode      <= 3'd0;
            ctrl0     <= {SYNC_INV, SYNC_INV};
            ctrl1     <= 2'b00;
            ctrl2     <= 2'b00;
            island0   <= 4'd0;
            island1   <= 4'd0;
            island2   <= 4'd0;
            pkt_ready <= 1'b0;
            underflow <= 1'b0;
        end else begin
            cx        <= cx_next;
            cy        <= cy_next;
            mode      <= mode_d;
            ctrl0     <= {vsync_w, hsync_w};
            ctrl1     <= ctrl1_d;
            ctrl2     <= ctrl2_d;
            island0   <= island0_d;
            island1   <= island1_d;
            island2   <= island2_d;
            pkt_ready <= ready_d;
            underflow <= underflow_d;
        end
    end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Testbench for hdmi_period_scheduler. One instance uses the default 640x480
// timing. A second instance shortens the frame to 12 lines (6 active, vsync on
// lines 8..9) with SYNC_INVERT=0, so that frame wrap and vsync can be reached
// quickly. Both share the packet stream.
// The packet source presents slot s during the cycle before the DATA pixel
// that shows it.
module tb_hdmi_period_scheduler;

    typedef struct {
        int         ln;
        int         px;
        logic [2:0] mode;
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        logic       rdy;
        logic       uf;
    } vec_t;

    localparam int RESET_AT = 13 * 800 + 669;

    logic        clk_pixel;
    logic        reset_n;
    logic        pkt_valid;
    logic        pkt_header;
    logic [3:0]  pkt_ch1, pkt_ch2;
    logic        pkt_ready, underflow, pkt_ready_v, underflow_v;
    logic [11:0] cx, cx_v;
    logic [10:0] cy, cy_v;
    logic [2:0]  mode, mode_v;
    logic [1:0]  ctrl0, ctrl1, ctrl2, ctrl0_v, ctrl1_v, ctrl2_v;
    logic [3:0]  island0, island1, island2, island0_v, island1_v, island2_v;

    int   checks = 0;
    int   errors = 0;
    bit   valid_en;
    vec_t main_tab[$];
    vec_t vt_tab[$];
    vec_t post_tab[$];

    hdmi_period_scheduler dut (
        .clk_pixel(clk_pixel), .reset_n(reset_n),
        .pkt_valid(pkt_valid), .pkt_header(pkt_header),
        .pkt_ch1(pkt_ch1), .pkt_ch2(pkt_ch2),
        .pkt_ready(pkt_ready), .underflow(underflow),
        .cx(cx), .cy(cy), .mode(mode),
        .ctrl0(ctrl0), .ctrl1(ctrl1), .ctrl2(ctrl2),
        .island0(island0), .island1(island1), .island2(island2)
    );

    hdmi_period_scheduler #(
        .V_ACTIVE(6), .V_TOTAL(12), .V_SYNC_START(8), .V_SYNC_SIZE(2), .SYNC_INVERT(0)
    ) dut_v (
        .clk_pixel(clk_pixel), .reset_n(reset_n),
        .pkt_valid(pkt_valid), .pkt_header(pkt_header),
        .pkt_ch1(pkt_ch1), .pkt_ch2(pkt_ch2),
        .pkt_ready(pkt_ready_v), .underflow(underflow_v),
        .cx(cx_v), .cy(cy_v), .mode(mode_v),
        .ctrl0(ctrl0_v), .ctrl1(ctrl1_v), .ctrl2(ctrl2_v),
        .island0(island0_v), .island1(island1_v), .island2(island2_v)
    );

    // Free-running pixel clock.
    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic addVec(inout vec_t q[$], input int ln, input int px, input int md,
                          input int c0, input int c1, input int c2, input int rdy, input int uf);
        vec_t v;
        v.ln = ln; v.px = px; v.mode = 3'(md);
        v.c0 = 2'(c0); v.c1 = 2'(c1); v.c2 = 2'(c2);
        v.rdy = 1'(rdy); v.uf = 1'(uf);
        q.push_back(v);
    endtask

    task automatic checkRecord(input vec_t v, input int vtot, input string tag,
                               input logic [11:0] acx, input logic [10:0] acy, input logic [2:0] amode,
                               input logic [1:0] a0, input logic [1:0] a1, input logic [1:0] a2,
                               input logic ardy, input logic auf);
        string p;
        p = $sformatf("%s(%0d,%0d)", tag, v.ln, v.px);
        checkOutput({p, " cx"}, 32'(acx), 32'(v.px));
        checkOutput({p, " cy"}, 32'(acy), 32'(v.ln % vtot));
        checkOutput({p, " mode"}, 32'(amode), 32'(v.mode));
        checkOutput({p, " ctrl0"}, 32'(a0), 32'(v.c0));
        if (v.mode == 3'd0) begin
            checkOutput({p, " ctrl1"}, 32'(a1), 32'(v.c1));
            checkOutput({p, " ctrl2"}, 32'(a2), 32'(v.c2));
        end
        checkOutput({p, " pkt_ready"}, 32'(ardy), 32'(v.rdy));
        checkOutput({p, " underflow"}, 32'(auf), 32'(v.uf));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " cx"}, 32'(cx), 32'd0);
        checkOutput({tag, " cy"}, 32'(cy), 32'd0);
        checkOutput({tag, " mode"}, 32'(mode), 32'd0);
        checkOutput({tag, " pkt_ready"}, 32'(pkt_ready), 32'd0);
        checkOutput({tag, " underflow"}, 32'(underflow), 32'd0);
        checkOutput({tag, " ctrl0"}, 32'(ctrl0), 32'd3);
        checkOutput({tag, " ctrl1/2"}, 32'({ctrl1, ctrl2}), 32'd0);
        checkOutput({tag, " island"}, 32'({island0, island1, island2}), 32'd0);
        checkOutput({tag, " ctrl0_v"}, 32'(ctrl0_v), 32'd0);
        checkOutput({tag, " cx_v"}, 32'(cx_v), 32'd0);
    endtask

    // Island contents expected on main-DUT line 1, where slot 10 is starved.
    task automatic checkIsland(input int px);
        logic [3:0] e0, e1, e2;
        logic [4:0] sl;
        logic       hs, hdr;
        e0 = 4'd0; e1 = 4'd0; e2 = 4'd0;
        if (px >= 654 && px <= 685) begin
            sl  = 5'(px - 654);
            hs  = (px >= 656 && px < 752) ? 1'b0 : 1'b1;
            hdr = sl[0];
            e1  = sl[3:0];
            e2  = ~sl[3:0];
            if (px == 664) begin
                hdr = 1'b0; e1 = 4'd0; e2 = 4'd0;
            end
            e0 = {sl != 5'd0, hdr, 1'b1, hs};
        end
        checkOutput($sformatf("island0(1,%0d)", px), 32'(island0), 32'(e0));
        checkOutput($sformatf("island1(1,%0d)", px), 32'(island1), 32'(e1));
        checkOutput($sformatf("island2(1,%0d)", px), 32'(island2), 32'(e2));
    endtask

    // Drive the packet stream for the edge that produces pixel m (counted from reset release).
    task automatic applyStimulus(input int m);
        int         px, ln;
        logic [4:0] sl;
        bit         drop;
        px   = m % 800;
        ln   = m / 800;
        drop = (ln == 1) && (px == 664);
        pkt_valid  = valid_en && (ln != 0) && !drop;
        pkt_header = 1'b0;
        pkt_ch1    = 4'h5;
        pkt_ch2    = 4'hA;
        if (px >= 654 && px <= 685) begin
            sl = 5'(px - 654);
            if (drop) begin
                pkt_header = 1'b1; pkt_ch1 = 4'hF; pkt_ch2 = 4'hF;
            end else begin
                pkt_header = sl[0]; pkt_ch1 = sl[3:0]; pkt_ch2 = ~sl[3:0];
            end
        end
    endtask

    initial begin
        int mi, vi, pi;
        int bcx, bcy;

        // Main DUT checkpoints: ln, px, mode, ctrl0, ctrl1, ctrl2, pkt_ready, underflow.
        addVec(main_tab, 0, 1, 1, 3, 0, 0, 0, 0);
        addVec(main_tab, 0, 639, 1, 3, 0, 0, 0, 0);
        addVec(main_tab, 0, 640, 0, 3, 0, 0, 0, 0);
        addVec(main_tab, 0, 644, 0, 3, 0, 0, 0, 0);
        addVec(main_tab, 0, 656, 0, 2, 0, 0, 0, 0);
        addVec(main_tab, 0, 751, 0, 2, 0, 0, 0, 0);
        addVec(main_tab, 0, 752, 0, 3, 0, 0, 0, 0);
        addVec(main_tab, 0, 789, 0, 3, 0, 0, 0, 0);
        addVec(main_tab, 0, 790, 0, 3, 1, 0, 0, 0);
        addVec(main_tab, 0, 797, 0, 3, 1, 0, 0, 0);
        addVec(main_tab, 0, 798, 2, 3, 0, 0, 0, 0);
        addVec(main_tab, 0, 799, 2, 3, 0, 0, 0, 0);
        addVec(main_tab, 1, 0, 1, 3, 0, 0, 0, 0);
        addVec(main_tab, 1, 643, 0, 3, 0, 0, 0, 0);
        addVec(main_tab, 1, 644, 0, 3, 1, 1, 0, 0);
        addVec(main_tab, 1, 651, 0, 3, 1, 1, 0, 0);
        addVec(main_tab, 1, 652, 4, 3, 0, 0, 0, 0);
        addVec(main_tab, 1, 653, 4, 3, 0, 0, 0, 0);
        addVec(main_tab, 1, 654, 3, 3, 0, 0, 1, 0);
        addVec(main_tab, 1, 663, 3, 2, 0, 0, 1, 0);
        addVec(main_tab, 1, 664, 3, 2, 0, 0, 1, 1);
        addVec(main_tab, 1, 685, 3, 2, 0, 0, 1, 1);
        addVec(main_tab, 1, 686, 4, 2, 0, 0, 0, 1);
        addVec(main_tab, 1, 687, 4, 2, 0, 0, 0, 1);
        addVec(main_tab, 1, 688, 0, 2, 0, 0, 0, 1);
        addVec(main_tab, 12, 798, 2, 3, 0, 0, 0, 1);
        addVec(main_tab, 13, 644, 0, 3, 1, 1, 0, 1);
        addVec(main_tab, 13, 669, 3, 2, 0, 0, 1, 1);

        // Short-frame DUT (12 lines, 6 active, vsync lines 8..9, sync active-high).
        addVec(vt_tab, 0, 100, 1, 0, 0, 0, 0, 0);
        addVec(vt_tab, 0, 656, 0, 1, 0, 0, 0, 0);
        addVec(vt_tab, 0, 751, 0, 1, 0, 0, 0, 0);
        addVec(vt_tab, 0, 752, 0, 0, 0, 0, 0, 0);
        addVec(vt_tab, 4, 798, 2, 0, 0, 0, 0, 1);
        addVec(vt_tab, 5, 639, 1, 0, 0, 0, 0, 1);
        addVec(vt_tab, 5, 790, 0, 0, 0, 0, 0, 1);
        addVec(vt_tab, 5, 798, 0, 0, 0, 0, 0, 1);
        addVec(vt_tab, 7, 0, 0, 0, 0, 0, 0, 1);
        addVec(vt_tab, 7, 644, 0, 0, 1, 1, 0, 1);
        addVec(vt_tab, 7, 660, 3, 1, 0, 0, 1, 1);
        addVec(vt_tab, 8, 0, 0, 2, 0, 0, 0, 1);
        addVec(vt_tab, 9, 700, 0, 3, 0, 0, 0, 1);
        addVec(vt_tab, 10, 0, 0, 0, 0, 0, 0, 1);
        addVec(vt_tab, 11, 790, 0, 0, 1, 0, 0, 1);
        addVec(vt_tab, 11, 797, 0, 0, 1, 0, 0, 1);
        addVec(vt_tab, 11, 798, 2, 0, 0, 0, 0, 1);
        addVec(vt_tab, 12, 0, 1, 0, 0, 0, 0, 1);
        addVec(vt_tab, 12, 639, 1, 0, 0, 0, 0, 1);

        // Main DUT after the mid-island reset, with the source idle.
        addVec(post_tab, 0, 1, 1, 3, 0, 0, 0, 0);
        addVec(post_tab, 0, 644, 0, 3, 0, 0, 0, 0);
        addVec(post_tab, 0, 660, 0, 2, 0, 0, 0, 0);
        addVec(post_tab, 0, 790, 0, 3, 1, 0, 0, 0);
        addVec(post_tab, 0, 799, 2, 3, 0, 0, 0, 0);

        reset_n  = 1'b0;
        valid_en = 1'b1;
        pkt_valid = 1'b0; pkt_header = 1'b0; pkt_ch1 = 4'd0; pkt_ch2 = 4'd0;
        repeat (3) @(negedge clk_pixel);
        checkReset("reset");
        reset_n = 1'b1;

        mi = 0; vi = 0;
        for (int k = 0; k <= RESET_AT; k++) begin
            bcx = k % 800;
            bcy = k / 800;
            while (mi < main_tab.size() && main_tab[mi].ln == bcy && main_tab[mi].px == bcx) begin
                checkRecord(main_tab[mi], 525, "main", cx, cy, mode, ctrl0, ctrl1, ctrl2, pkt_ready, underflow);
                mi++;
            end
            while (vi < vt_tab.size() && vt_tab[vi].ln == bcy && vt_tab[vi].px == bcx) begin
                checkRecord(vt_tab[vi], 12, "short", cx_v, cy_v, mode_v, ctrl0_v, ctrl1_v, ctrl2_v, pkt_ready_v, underflow_v);
                vi++;
            end
            if (bcy == 1 && bcx >= 652 && bcx <= 687) checkIsland(bcx);
            if (bcy == 7 && bcx == 660) begin
                checkOutput("island0_v(7,660)", 32'(island0_v), 32'h9);
                checkOutput("island1_v(7,660)", 32'(island1_v), 32'h6);
                checkOutput("island2_v(7,660)", 32'(island2_v), 32'h9);
            end
            if (k == RESET_AT) break;
            applyStimulus(k + 1);
            @(posedge clk_pixel);
            @(negedge clk_pixel);
        end
        checkOutput("table main consumed", 32'(mi), 32'(main_tab.size()));
        checkOutput("table short consumed", 32'(vi), 32'(vt_tab.size()));

        // Reset in the middle of island slot 15 takes effect without a clock edge.
        reset_n = 1'b0;
        #1;
        checkReset("mid-island reset");
        valid_en  = 1'b0;
        pkt_valid = 1'b0;
        repeat (2) @(negedge clk_pixel);
        reset_n = 1'b1;
        #1;
        checkReset("release");

        pi = 0;
        for (int k = 0; k < 800; k++) begin
            bcx = k % 800;
            while (pi < post_tab.size() && post_tab[pi].px == bcx) begin
                checkRecord(post_tab[pi], 525, "post", cx, cy, mode, ctrl0, ctrl1, ctrl2, pkt_ready, underflow);
                pi++;
            end
            applyStimulus(k + 1);
            @(posedge clk_pixel);
            @(negedge clk_pixel);
        end
        checkOutput("table post consumed", 32'(pi), 32'(post_tab.size()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
